// File: rtl/id_ex_if.sv
// Bundle between the IF/ID side, the write-back port and the ALU-facing ID/EX outputs.
// The master drives the instruction and write-back fields. The slave is the stage.
interface id_ex_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic [31:0]           instr;
  logic                  stall;
  logic                  flush;
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [1:0]            alu_op;
  logic [5:0]            funct;
  logic [4:0]            shamt;
  logic [4:0]            dest;
  logic                  reg_write;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] store_data;

  modport master (
    output in_valid, instr, stall, flush, wb_en, wb_addr, wb_data,
    input  out_valid, a, b, alu_op, funct, shamt, dest,
           reg_write, mem_read, mem_write, store_data
  );

  modport slave (
    input  in_valid, instr, stall, flush, wb_en, wb_addr, wb_data,
    output out_valid, a, b, alu_op, funct, shamt, dest,
           reg_write, mem_read, mem_write, store_data
  );
endinterface

// File: rtl/id_ex_stage.sv
// MIPS decode / operand-fetch stage: 32-entry register file with write-through,
// immediate sign extension, and the ID/EX pipeline register feeding the ALU.
module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic     clk,
  input  logic     rst,
  id_ex_if.slave   bus
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FN   = 2'b10;

  logic [DATA_WIDTH-1:0] rf_q [2**REG_ADDR_W];

  logic [5:0]            opcode;
  logic [REG_ADDR_W-1:0] rs, rt;
  logic [DATA_WIDTH-1:0] rs_val, rt_val;
  logic signed [DATA_WIDTH-1:0] imm_ext;

  logic                  out_valid_d, out_valid_q;
  logic [DATA_WIDTH-1:0] a_d, a_q, b_d, b_q, store_data_d, store_data_q;
  logic [1:0]            alu_op_d, alu_op_q;
  logic [5:0]            funct_d, funct_q;
  logic [4:0]            shamt_d, shamt_q, dest_d, dest_q;
  logic                  reg_write_d, reg_write_q;
  logic                  mem_read_d, mem_read_q;
  logic                  mem_write_d, mem_write_q;
  logic                  supported;

  assign opcode  = bus.instr[31:26];
  assign rs      = REG_ADDR_W'(bus.instr[25:21]);
  assign rt      = REG_ADDR_W'(bus.instr[20:16]);
  assign imm_ext = DATA_WIDTH'(signed'(bus.instr[15:0]));

  // Write-through: a write-back landing this cycle is visible to the decode reading it.
  assign rs_val = (rs == '0) ? '0 :
                  (bus.wb_en && bus.wb_addr == rs) ? bus.wb_data : rf_q[rs];
  assign rt_val = (rt == '0) ? '0 :
                  (bus.wb_en && bus.wb_addr == rt) ? bus.wb_data : rf_q[rt];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**REG_ADDR_W; i++) rf_q[i] <= '0;
    end else if (bus.wb_en && bus.wb_addr != '0) begin
      rf_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_comb begin
    supported    = 1'b1;
    out_valid_d  = 1'b0;
    a_d          = rs_val;
    b_d          = rt_val;
    store_data_d = '0;
    alu_op_d     = ALU_ADD;
    funct_d      = bus.instr[5:0];
    shamt_d      = bus.instr[10:6];
    dest_d       = '0;
    reg_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        alu_op_d    = ALU_FN;
        dest_d      = bus.instr[15:11];
        reg_write_d = 1'b1;
      end
      OP_ADDI: begin
        b_d         = imm_ext;
        dest_d      = bus.instr[20:16];
        reg_write_d = 1'b1;
      end
      OP_LW: begin
        b_d         = imm_ext;
        dest_d      = bus.instr[20:16];
        reg_write_d = 1'b1;
        mem_read_d  = 1'b1;
      end
      OP_SW: begin
        b_d          = imm_ext;
        store_data_d = rt_val;
        mem_write_d  = 1'b1;
      end
      OP_BEQ: alu_op_d = ALU_SUB;
      default: supported = 1'b0;
    endcase
    // Unsupported opcodes and empty slots both become a fully zeroed bubble.
    if (!bus.in_valid || !supported) begin
      a_d          = '0;
      b_d          = '0;
      store_data_d = '0;
      alu_op_d     = '0;
      funct_d      = '0;
      shamt_d      = '0;
      dest_d       = '0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
    end else begin
      out_valid_d  = 1'b1;
    end
  end

  // ID/EX register: rst > flush > stall > load
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      out_valid_q  <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      store_data_q <= '0;
      alu_op_q     <= '0;
      funct_q      <= '0;
      shamt_q      <= '0;
      dest_q       <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else if (!bus.stall) begin
      out_valid_q  <= out_valid_d;
      a_q          <= a_d;
      b_q          <= b_d;
      store_data_q <= store_data_d;
      alu_op_q     <= alu_op_d;
      funct_q      <= funct_d;
      shamt_q      <= shamt_d;
      dest_q       <= dest_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.a          = a_q;
  assign bus.b          = b_q;
  assign bus.store_data = store_data_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.funct      = funct_q;
  assign bus.shamt      = shamt_q;
  assign bus.dest       = dest_q;
  assign bus.reg_write  = reg_write_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a decode vector table plus hand-written
// stall / flush / reset sequences, all with hand-computed expectations.
module tb_id_ex_stage;
  typedef struct packed {
    logic        ov;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  alu;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [31:0] sd;
  } exp_t;

  typedef struct packed {
    logic        in_valid;
    logic [31:0] instr;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  id_ex_if bus ();

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    chk({tag, ".out_valid"},  32'(bus.out_valid),  32'(e.ov));
    chk({tag, ".a"},          bus.a,               e.a);
    chk({tag, ".b"},          bus.b,               e.b);
    chk({tag, ".alu_op"},     32'(bus.alu_op),     32'(e.alu));
    chk({tag, ".funct"},      32'(bus.funct),      32'(e.funct));
    chk({tag, ".shamt"},      32'(bus.shamt),      32'(e.shamt));
    chk({tag, ".dest"},       32'(bus.dest),       32'(e.dest));
    chk({tag, ".reg_write"},  32'(bus.reg_write),  32'(e.rw));
    chk({tag, ".mem_read"},   32'(bus.mem_read),   32'(e.mr));
    chk({tag, ".mem_write"},  32'(bus.mem_write),  32'(e.mw));
    chk({tag, ".store_data"}, bus.store_data,      e.sd);
  endtask

  // One cycle: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic iv, input logic [31:0] ins,
                      input logic st, input logic fl,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    rst          = r;
    bus.in_valid = iv;
    bus.instr    = ins;
    bus.stall    = st;
    bus.flush    = fl;
    bus.wb_en    = we;
    bus.wb_addr  = wa;
    bus.wb_data  = wd;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ADD_1_5_6  = 32'h00A60820;
  localparam logic [31:0] LW_2_M4_5  = 32'h8CA2FFFC;
  localparam logic [31:0] SW_6_8_5   = 32'hACA60008;
  localparam logic [31:0] BEQ_5_6_4  = 32'h10A60004;
  localparam logic [31:0] ADDI_7_6_M = 32'h20C7FFFF;
  localparam logic [31:0] ADD_1_0_6  = 32'h00060820;
  localparam logic [31:0] ADD_3_7_8  = 32'h00E81820;
  localparam logic [31:0] OP_3F      = 32'hFC000000;

  localparam exp_t ZERO = '0;

  vec_t vecs [10];
  exp_t e_add55, e_lw99, e_addz;

  initial begin
    vecs[0] = '{1'b1, ADD_1_5_6,  1'b0, 1'b0, 5'd0, 32'h0,
                '{1'b1, 32'd7, 32'd3, 2'b10, 6'h20, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0}};
    vecs[1] = '{1'b1, LW_2_M4_5,  1'b0, 1'b0, 5'd0, 32'h0,
                '{1'b1, 32'd7, 32'hFFFF_FFFC, 2'b00, 6'h3C, 5'd31, 5'd2, 1'b1, 1'b1, 1'b0, 32'h0}};
    vecs[2] = '{1'b1, SW_6_8_5,   1'b0, 1'b0, 5'd0, 32'h0,
                '{1'b1, 32'd7, 32'd8, 2'b00, 6'h08, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd3}};
    vecs[3] = '{1'b1, BEQ_5_6_4,  1'b0, 1'b0, 5'd0, 32'h0,
                '{1'b1, 32'd7, 32'd3, 2'b01, 6'h04, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0}};
    vecs[4] = '{1'b1, ADDI_7_6_M, 1'b0, 1'b0, 5'd0, 32'h0,
                '{1'b1, 32'd3, 32'hFFFF_FFFF, 2'b00, 6'h3F, 5'd31, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0}};
    // write-through of R5 in the same cycle as the read; R5 keeps 0x55 afterwards
    vecs[5] = '{1'b1, ADD_1_5_6,  1'b0, 1'b1, 5'd5, 32'h55,
                '{1'b1, 32'h55, 32'd3, 2'b10, 6'h20, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0}};
    // write to R0 must neither bypass nor stick
    vecs[6] = '{1'b1, ADD_1_0_6,  1'b0, 1'b1, 5'd0, 32'hFF,
                '{1'b1, 32'd0, 32'd3, 2'b10, 6'h20, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0}};
    vecs[7] = '{1'b1, OP_3F,      1'b0, 1'b0, 5'd0, 32'h0, ZERO};
    vecs[8] = '{1'b0, SW_6_8_5,   1'b0, 1'b0, 5'd0, 32'h0, ZERO};
    vecs[9] = '{1'b1, ADD_1_5_6,  1'b1, 1'b0, 5'd0, 32'h0, ZERO};

    e_add55 = '{1'b1, 32'h55, 32'd3, 2'b10, 6'h20, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0};
    e_lw99  = '{1'b1, 32'h99, 32'hFFFF_FFFC, 2'b00, 6'h3C, 5'd31, 5'd2, 1'b1, 1'b1, 1'b0, 32'h0};
    e_addz  = '{1'b1, 32'd0, 32'd0, 2'b10, 6'h20, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.instr = '0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;

    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    check_outs("reset", ZERO);
    step(1'b0, 1'b1, ADD_3_7_8, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    check_outs("rf_cleared", '{1'b1, 32'd0, 32'd0, 2'b10, 6'h20, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0});

    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 32'd7);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd6, 32'd3);

    for (int i = 0; i < 10; i++) begin
      step(1'b0, vecs[i].in_valid, vecs[i].instr, 1'b0, vecs[i].flush,
           vecs[i].wb_en, vecs[i].wb_addr, vecs[i].wb_data);
      check_outs($sformatf("vec%0d", i), vecs[i].e);
    end

    // Stall holds contents even while R5 is rewritten underneath
    step(1'b0, 1'b1, ADD_1_5_6, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    check_outs("pre_stall", e_add55);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, LW_2_M4_5, 1'b1, 1'b0, 1'b1, 5'd5, 32'h99);
      check_outs($sformatf("stall%0d", i), e_add55);
    end
    step(1'b0, 1'b1, LW_2_M4_5, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    check_outs("stall_release", e_lw99);

    step(1'b0, 1'b1, ADD_1_5_6, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    check_outs("flush_over_stall", ZERO);

    // Reset during a stall empties the stage and clears the register file
    step(1'b0, 1'b1, ADD_1_5_6, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 1'b1, ADD_1_5_6, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    check_outs("rst_mid_stall", ZERO);
    step(1'b0, 1'b1, ADD_1_5_6, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    check_outs("post_rst_read", e_addz);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
